// File: rtl/core2_gf_mul_responder.sv
// Digit-serial carry-less multiplier with a 2-entry first-word-fall-through result FIFO.
// Optional build macro CORE2_SQR_FAST_EN: squaring (cmd 10) by bit interleave, skipping MULT.
module core2_gf_mul_responder #(
  parameter int WIDTH = 128,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_inp,
  input  logic [WIDTH-1:0]   data_in_a,
  input  logic [WIDTH-1:0]   data_in_b,
  input  logic [1:0]         data_in_cmd,
  output logic               in_busy,
  input  logic               rd_en_out,
  output logic [2*WIDTH-1:0] data_out,
  output logic               out_busy,
  output logic               ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    PUSH
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   mem_q [2];
  logic [W2-1:0]   mem_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            push;
  logic            pop;
  logic            accept;
  logic [W2-1:0]   part;

  assign in_busy  = (state_q != IDLE);
  assign out_busy = (count_q == 2'd0);
  assign ovf      = ovf_q;
  assign data_out = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];

  assign accept = wr_en_inp && (state_q == IDLE);
  assign pop    = rd_en_out && (count_q != 2'd0);
  assign push   = (state_q == PUSH) && ((count_q != 2'd2) || pop);

  // Partial product of A with the top DIGIT bits of the shifting B.
  always_comb begin
    part = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (b_q[WIDTH-DIGIT+j]) begin
        part = part ^ ({{WIDTH{1'b0}}, a_q} << j);
      end
    end
  end

`ifdef CORE2_SQR_FAST_EN
  logic [W2-1:0] sq_in;

  always_comb begin
    sq_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sq_in[2*i] = data_in_a[i];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (data_in_cmd != 2'b00)) begin
          a_d     = data_in_a;
          b_d     = (data_in_cmd == 2'b10) ? data_in_a : data_in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MULT;
`ifdef CORE2_SQR_FAST_EN
          if (data_in_cmd == 2'b10) begin
            acc_d   = sq_in;
            state_d = PUSH;
          end
`endif
        end
      end
      MULT: begin
        acc_d = (acc_q << DIGIT) ^ part;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (push) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en_inp & in_busy);
    if (push) begin
      mem_d[wr_ptr_q] = acc_q;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: doc/core2_gf_mul_responder.md
CORE2_GF_MUL_RESPONDER -- requirements
Module: core2_gf_mul_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 128, giving the operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, giving the operand-B bits consumed per multiply cycle; DIGIT SHALL divide WIDTH.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_en_inp  input  1  operand/command push strobe.
REQ-006 SHALL have port data_in_a  input  WIDTH  operand A.
REQ-007 SHALL have port data_in_b  input  WIDTH  operand B.
REQ-008 SHALL have port data_in_cmd  input  2  command: 01 multiply, 10 square A, 11 multiply, 00 NOP.
REQ-009 SHALL have port in_busy  output  1  high when an operand cannot be accepted.
REQ-010 SHALL have port rd_en_out  input  1  result pop strobe.
REQ-011 SHALL have port data_out  output  2*WIDTH  head result entry, first-word fall-through.
REQ-012 SHALL have port out_busy  output  1  high when the result FIFO is empty.
REQ-013 SHALL have port ovf  output  1  sticky flag: push attempted while in_busy.

Function
REQ-014 SHALL accept an operand on a rising edge where wr_en_inp=1 and in_busy=0, latching A, B and cmd.
REQ-015 SHALL use states IDLE, MULT, PUSH; in_busy SHALL be 0 only in IDLE.
REQ-016 SHALL, on accept: cmd 00 stay in IDLE with no result; cmd 01/11 go to MULT; cmd 10 go to MULT with B replaced by A.
REQ-017 SHALL compute the carry-less (GF(2) polynomial) product, unreduced, zero-extended to 2*WIDTH bits (bit 2*WIDTH-1 always 0).
REQ-018 SHALL in MULT process DIGIT bits of B per edge, MSB-first (acc = (acc<<DIGIT) XOR partials), for exactly WIDTH/DIGIT edges, then enter PUSH.
REQ-019 SHALL in PUSH write acc into the result FIFO on the edge where the FIFO is not full or rd_en_out=1 pops that same edge, then return to IDLE; otherwise hold in PUSH.
REQ-020 SHALL give latency: accept on edge E0, multiply on E1..E(WIDTH/DIGIT), push on E(WIDTH/DIGIT+1), out_busy low after that edge when the FIFO was empty (E33 at defaults).
REQ-021 SHALL use a 2-entry result FIFO; data_out SHALL show the oldest entry; data_out SHALL be 0 when empty.
REQ-022 SHALL ignore rd_en_out while out_busy=1, with no pointer change.
REQ-023 SHALL, on a simultaneous push and pop with the FIFO full, pop the head and write the new entry, keeping the count at 2.
REQ-024 SHALL drop wr_en_inp while in_busy=1, leave the in-flight operation intact, and set ovf until reset.

Reset
REQ-025 SHALL, while rst_n=0, force: state IDLE, in_busy 0, out_busy 1, data_out 0, ovf 0, FIFO count 0, accumulator, digit counter and operand registers 0.
REQ-026 SHALL, on reset mid-MULT or mid-PUSH, discard the operation and emit no result after release.

Configuration
REQ-027 SHALL honour macro CORE2_SQR_FAST_EN; when defined, cmd 10 SHALL bypass MULT, load acc with A bits interleaved with zeros (bit i to bit 2i) on E0, and push on E1.
REQ-028 SHALL, without CORE2_SQR_FAST_EN, route cmd 10 through MULT per REQ-016 with the REQ-020 latency.

Verification
REQ-029 SHALL test A=0x2, B=0x3, cmd 01 -> out_busy low after E33, data_out=0x6; rd_en_out -> out_busy high.
REQ-030 SHALL test A=B=1<<127, cmd 01 -> data_out=1<<254, upper bit 255 = 0.
REQ-031 SHALL test A=0x3, cmd 10 -> data_out=0x5, after E1 with CORE2_SQR_FAST_EN and after E33 without.
REQ-032 SHALL test three multiplies (2x3, 3x3, 4x5) with no reads -> the first two enter the FIFO; the third holds in PUSH with in_busy=1. One pop then yields 0x6, 0x5, 0x14 in order.
REQ-033 SHALL test wr_en_inp during MULT -> ovf=1 and the in-flight result is unchanged; a pulse of rst_n=0 at E10 of a multiply -> out_busy stays 1 and ovf=0.
